servo_position_ramp: RTL

- Command stage directly upstream of the servo PWM generator.
- Synchronises and debounces three raw position switches and selects a target pulse-width offset.
- Ramps the 18-bit control word toward that target by a bounded step once per 20 ms servo frame, so the servo never sees a step jump.
- The PWM stage consumes control and frame_sync.

---
 rtl/servo_pkg.sv | 10 +
 rtl/switch_debounce.sv | 34 +++
 rtl/servo_position_ramp.sv | 90 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: shared ramp state, control width and default frame/position constants
// for the servo command stage and the PWM generator.
package servo_pkg;
    localparam int CTRL_W = 18;
    localparam int DEF_FRAME_CYCLES = 2000000;
    localparam logic [CTRL_W-1:0] DEF_POS_A = 18'd0;
    localparam logic [CTRL_W-1:0] DEF_POS_B = 18'd50000;
    localparam logic [CTRL_W-1:0] DEF_POS_C = 18'd100000;
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} ramp_state_e;
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: 2-flop synchroniser followed by a stability counter; the
// debounced level only follows the synchronised input after DEBOUNCE_CYCLES of agreement.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sw_raw,
    output logic level
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic meta_q, sync_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // The counter runs only while the new level persists; any return to the accepted level restarts it.
    always_comb begin
        cnt_d   = (sync_q == level_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        level_d = (sync_q != level_q && cnt_q == CNT_LAST) ? sync_q : level_q;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= sw_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign level = level_q;
endmodule

// File: rtl/servo_position_ramp.sv
// servo_position_ramp: debounced three-position select that slews the servo control word
// toward its target by at most STEP per frame, updating only at frame boundaries.
module servo_position_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP = 500,
    parameter logic [CTRL_W-1:0] POS_A = DEF_POS_A,
    parameter logic [CTRL_W-1:0] POS_B = DEF_POS_B,
    parameter logic [CTRL_W-1:0] POS_C = DEF_POS_C
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sw8,
    input  logic              sw9,
    input  logic              sw10,
    output logic [CTRL_W-1:0] control,
    output logic              frame_sync,
    output logic              at_target,
    output logic              busy
);
    localparam int FW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
    localparam logic [CTRL_W:0] STEP_W = (CTRL_W + 1)'(STEP);
    logic db8, db9, db10, update, at_target_q;
    logic [CTRL_W-1:0] control_q, control_d, target_q, target_d;
    logic [CTRL_W:0] gap_up, gap_dn;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    ramp_state_e state_q, state_d;

    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw8 (
        .clock(clock), .reset_n(reset_n), .sw_raw(sw8), .level(db8));
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw9 (
        .clock(clock), .reset_n(reset_n), .sw_raw(sw9), .level(db9));
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw10 (
        .clock(clock), .reset_n(reset_n), .sw_raw(sw10), .level(db10));

    always_comb begin
        target_d    = db10 ? POS_C : db9 ? POS_B : db8 ? POS_A : target_q;
        update      = frame_cnt_q == FRAME_LAST;
        frame_cnt_d = update ? '0 : frame_cnt_q + 1'b1;
        gap_up      = {1'b0, target_q} - {1'b0, control_q};
        gap_dn      = {1'b0, control_q} - {1'b0, target_q};
        control_d   = control_q;
        state_d     = state_q;
        case (state_q)
            IDLE: state_d = target_q > control_q ? RAMP_UP : target_q < control_q ? RAMP_DOWN : IDLE;
            RAMP_UP: begin
                if (target_q < control_q) state_d = RAMP_DOWN;
                else if (target_q == control_q) state_d = IDLE;
                else if (update) begin
                    control_d = gap_up <= STEP_W ? target_q : control_q + CTRL_W'(STEP);
                    state_d   = gap_up <= STEP_W ? IDLE : RAMP_UP;
                end
            end
            RAMP_DOWN: begin
                if (target_q > control_q) state_d = RAMP_UP;
                else if (target_q == control_q) state_d = IDLE;
                else if (update) begin
                    control_d = gap_dn <= STEP_W ? target_q : control_q - CTRL_W'(STEP);
                    state_d   = gap_dn <= STEP_W ? IDLE : RAMP_DOWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            control_q   <= '0;
            target_q    <= '0;
            frame_cnt_q <= '0;
            state_q     <= IDLE;
            at_target_q <= 1'b1;
        end else begin
            control_q   <= control_d;
            target_q    <= target_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            at_target_q <= control_q == target_q;
        end
    end

    // Gated by reset so the pulse is low in reset yet present in the first cycle after release.
    assign frame_sync = reset_n & (frame_cnt_q == '0);
    assign control    = control_q;
    assign at_target  = at_target_q;
    assign busy       = state_q != IDLE;
endmodule
